// File: rtl/stream_pkg.sv
// Shared helpers for the stream width adapters: lane count and a
// minimum-one-bit ceil(log2) used to size counters and lane indices.
package stream_pkg;

  // Number of narrow beats that make up one wide word.
  function automatic int lanes(input int s, input int m);
    return (s > 0) ? (m / s) : 1;
  endfunction

  // ceil(log2(v)) but never below 1, so a counter always has a real bit.
  function automatic int log2c(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/axis_fifo_sync.sv
// Small synchronous FIFO: power-of-2 depth, wrapping pointers, explicit
// level counter. Storage is reset so the head reads zero out of reset.
module axis_fifo_sync #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd_ready,
  output logic [WIDTH-1:0]           rdata,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign valid   = (level != '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = valid && rd_ready;
  assign do_push = push && !full;
  assign rdata   = mem[rd_ptr];

  // Word storage, written at the tail.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)       mem <= '0;
    else if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) level <= '0;
    else begin
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/axis_resync_upsizer.sv
// Narrow-to-wide AXI-Stream packer with resync: a stalled partial word is
// dropped on idle timeout or explicit flush, and counted. First beat of a
// word lands in the MSBs. Completed words go through a small output FIFO.
module axis_resync_upsizer
  import stream_pkg::*;
#(
  parameter int S_WIDTH        = 8,
  parameter int M_WIDTH        = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                              clk,
  input  logic                              arstn,
  input  logic [S_WIDTH-1:0]                s_axis_tdata,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  output logic [M_WIDTH-1:0]                m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  input  logic                              flush,
  output logic [CNT_WIDTH-1:0]              drop_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);
  localparam int N      = lanes(S_WIDTH, M_WIDTH);
  localparam int LANE_W = log2c(N);
  localparam int IDLE_W = log2c(TIMEOUT_CYCLES + 1);

  if (M_WIDTH % S_WIDTH != 0) begin : g_err_width
    $error("axis_resync_upsizer: M_WIDTH must be a multiple of S_WIDTH");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_err_depth
    $error("axis_resync_upsizer: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic [LANE_W-1:0]             lane_q, eff_lane;
  logic [IDLE_W-1:0]             idle_q;
  logic [N-1:0][S_WIDTH-1:0]     asm_q, asm_d;
  logic [M_WIDTH-1:0]            word_d;
  logic                          accept, last_lane, fifo_full;
  logic                          expire, flush_drop, drop, push;

  // Ready depends only on registered state: block only the word-completing beat when full.
  assign last_lane     = (lane_q == LANE_W'(N - 1));
  assign s_axis_tready = !last_lane || !fifo_full;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // An accepted beat always beats the timeout in the same cycle.
  if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
    assign expire = 1'b0;
  end else begin : g_timeout
    assign expire = (lane_q != '0) && !accept && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));
  end

  // Flush restarts the word before a same-cycle beat is placed.
  assign flush_drop = flush && (lane_q != '0);
  assign drop       = flush_drop || expire;
  assign eff_lane   = flush_drop ? '0 : lane_q;
  assign push       = accept && (eff_lane == LANE_W'(N - 1));

  // Drop the incoming beat into its lane; lane k sits k slots below the MSB slot.
  always_comb begin
    asm_d = asm_q;
    for (int k = 0; k < N; k++)
      if (accept && (eff_lane == LANE_W'(k))) asm_d[N-1-k] = s_axis_tdata;
  end

  assign word_d = asm_d;

  // Assembly register; stale lanes are overwritten before they are ever pushed.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) asm_q <= '0;
    else        asm_q <= asm_d;
  end

  // Lane counter: advance per beat, wrap on word completion, zero on a drop.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)      lane_q <= '0;
    else if (accept) lane_q <= push ? '0 : eff_lane + 1'b1;
    else if (drop)   lane_q <= '0;
  end

  // Idle counter only runs while a partial word is waiting.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)                                 idle_q <= '0;
    else if (accept || (lane_q == '0) || drop)  idle_q <= '0;
    else                                        idle_q <= idle_q + 1'b1;
  end

  // Saturating count of discarded partial words; timeout+flush together count once.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)                         drop_count <= '0;
    else if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
  end

  axis_fifo_sync #(
    .WIDTH (M_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .arstn    (arstn),
    .push     (push),
    .wdata    (word_d),
    .rd_ready (m_axis_tready),
    .rdata    (m_axis_tdata),
    .valid    (m_axis_tvalid),
    .full     (fifo_full),
    .level    (fifo_level)
  );

endmodule

// File: tb/tb_axis_resync_upsizer.sv
// Bench for axis_resync_upsizer (8->32, depth 4, timeout 16, 8-bit counter).
// A queue-based model of the packer runs alongside every cycle; a constant
// vector table and directed sequences cover the corner cases.
module tb_axis_resync_upsizer;
  localparam int N = 4;
  localparam int D = 4;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  drop_count;
  logic [2:0]  fifo_level;

  axis_resync_upsizer #(
    .S_WIDTH(8), .M_WIDTH(32), .FIFO_DEPTH(D), .TIMEOUT_CYCLES(T), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .arstn(arstn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .flush(flush), .drop_count(drop_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  part[$];
  logic [31:0] wq[$];
  int          idle_m = 0;
  int          drop_m = 0;

  int n_vec = 0;
  int n_bad = 0;

  // Outputs sampled at the last cycle() call (state before that cycle's edge)
  logic        smp_rdy, smp_vld;
  logic [31:0] smp_data;
  logic [2:0]  smp_lvl;
  logic [7:0]  smp_drop;

  typedef struct {
    logic        sv;
    logic [7:0]  d;
    logic        mr;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_data;
    logic [2:0]  e_lvl;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare with the model, then advance the model at posedge.
  task automatic cycle(input logic sv, input logic [7:0] d, input logic fl, input logic mr,
                       output logic acc);
    logic        exp_rdy, drop_now, pre_empty;
    logic [31:0] w;
    @(negedge clk);
    s_axis_tvalid = sv; s_axis_tdata = d; flush = fl; m_axis_tready = mr;
    smp_rdy = s_axis_tready; smp_vld = m_axis_tvalid; smp_data = m_axis_tdata;
    smp_lvl = fifo_level; smp_drop = drop_count;
    exp_rdy = !((part.size() == N - 1) && (wq.size() == D));
    chk("s_tready", 32'(smp_rdy), 32'(exp_rdy));
    chk("m_tvalid", 32'(smp_vld), 32'(wq.size() != 0));
    if (wq.size() != 0) chk("m_tdata", smp_data, wq[0]);
    chk("fifo_level", 32'(smp_lvl), 32'(wq.size()));
    chk("drop_count", 32'(smp_drop), 32'(drop_m));
    acc = sv && exp_rdy;
    @(posedge clk);
    pre_empty = (part.size() == 0);
    drop_now  = 1'b0;
    if (!pre_empty && (fl || (!acc && idle_m == T - 1))) begin
      part.delete();
      drop_now = 1'b1;
    end
    idle_m = (acc || pre_empty || drop_now) ? 0 : idle_m + 1;
    if (drop_now && drop_m < 255) drop_m++;
    if (mr && wq.size() != 0) void'(wq.pop_front());
    if (acc) begin
      part.push_back(d);
      if (part.size() == N) begin
        w = '0;
        foreach (part[i]) w = (w << 8) | 32'(part[i]);
        wq.push_back(w);
        part.delete();
      end
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic mr);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 64 && !acc; t++) cycle(1'b1, d, 1'b0, mr, acc);
    n_vec++;
    if (!acc) begin
      n_bad++;
      $display("FAIL send_beat: beat %h never accepted within 64 cycles", d);
    end
  endtask

  task automatic idle(input int n, input logic mr);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, mr, acc);
  endtask

  // Asynchronous reset, asserted away from any edge; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    s_axis_tvalid = 1'b0; flush = 1'b0; m_axis_tready = 1'b0;
    #2 arstn = 1'b0;
    #1;
    chk("rst_m_tvalid",   32'(m_axis_tvalid), 32'd0);
    chk("rst_m_tdata",    m_axis_tdata,       32'd0);
    chk("rst_fifo_level", 32'(fifo_level),    32'd0);
    chk("rst_drop_count", 32'(drop_count),    32'd0);
    chk("rst_s_tready",   32'(s_axis_tready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arstn = 1'b1;
    part.delete(); wq.delete(); idle_m = 0; drop_m = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   pv;

    // Back-to-back DEADBEEF: valid exactly one cycle after the fourth beat.
    tbl[0] = '{1'b1, 8'hDE, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
    tbl[1] = '{1'b1, 8'hAD, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
    tbl[2] = '{1'b1, 8'hBE, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
    tbl[3] = '{1'b1, 8'hEF, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 3'd1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};

    do_reset();
    foreach (tbl[i]) begin
      cycle(tbl[i].sv, tbl[i].d, 1'b0, tbl[i].mr, acc);
      chk("tbl_s_tready", 32'(smp_rdy), 32'(tbl[i].e_rdy));
      chk("tbl_m_tvalid", 32'(smp_vld), 32'(tbl[i].e_vld));
      chk("tbl_level",    32'(smp_lvl), 32'(tbl[i].e_lvl));
      if (tbl[i].e_vld) chk("tbl_m_tdata", smp_data, tbl[i].e_data);
    end

    // Backpressure: 16 beats fill the FIFO, 3 more reach lane 3, the 20th is held off.
    do_reset();
    for (int k = 0; k < 19; k++) send_beat(8'(k), 1'b0);
    cycle(1'b1, 8'd19, 1'b0, 1'b0, acc);
    chk("bp_level_full", 32'(smp_lvl), 32'd4);
    chk("bp_tready_low", 32'(smp_rdy), 32'd0);
    cycle(1'b1, 8'd19, 1'b0, 1'b0, acc);
    chk("bp_held_word0", smp_data, 32'h00010203);
    send_beat(8'd19, 1'b1);
    idle(8, 1'b1);

    // Timeout after 16 idle cycles, then a clean word.
    do_reset();
    send_beat(8'h11, 1'b0); send_beat(8'h22, 1'b0);
    idle(16, 1'b0);
    idle(1, 1'b0);
    chk("to_drop", 32'(smp_drop), 32'd1);
    send_beat(8'hA1, 1'b0); send_beat(8'hA2, 1'b0);
    send_beat(8'hA3, 1'b0); send_beat(8'hA4, 1'b0);
    idle(1, 1'b0);
    chk("to_word", smp_data, 32'hA1A2A3A4);

    // Beat on the 16th idle cycle keeps the word alive.
    do_reset();
    send_beat(8'h11, 1'b0); send_beat(8'h22, 1'b0);
    idle(15, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b0);
    idle(1, 1'b0);
    chk("edge_drop", 32'(smp_drop), 32'd0);
    chk("edge_word", smp_data, 32'h11223344);

    // Flush at lane 2 with a same-cycle beat: beat starts the next word.
    do_reset();
    send_beat(8'h01, 1'b0); send_beat(8'h02, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0, acc);
    send_beat(8'h66, 1'b0); send_beat(8'h77, 1'b0); send_beat(8'h88, 1'b0);
    idle(1, 1'b0);
    chk("fl_drop", 32'(smp_drop), 32'd1);
    chk("fl_word", smp_data, 32'h55667788);
    // Flush with nothing pending is a no-op.
    cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
    idle(1, 1'b0);
    chk("fl_idle_drop", 32'(smp_drop), 32'd1);

    // 300 timed-out partials saturate the counter.
    do_reset();
    for (int p = 0; p < 300; p++) begin
      send_beat(8'(p), 1'b1);
      idle(T, 1'b1);
    end
    idle(1, 1'b1);
    chk("sat_drop", 32'(smp_drop), 32'hFF);

    // Reset with a word buffered and a partial pending clears everything.
    send_beat(8'hB1, 1'b0); send_beat(8'hB2, 1'b0);
    send_beat(8'hB3, 1'b0); send_beat(8'hB4, 1'b0);
    send_beat(8'hB5, 1'b0); send_beat(8'hB6, 1'b0);
    do_reset();
    send_beat(8'hC1, 1'b0); send_beat(8'hC2, 1'b0);
    send_beat(8'hC3, 1'b0); send_beat(8'hC4, 1'b0);
    idle(1, 1'b0);
    chk("rst_word", smp_data, 32'hC1C2C3C4);
    chk("rst_level", 32'(smp_lvl), 32'd1);

    // Random traffic against the model, in phases of dense, sparse and near-idle input.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      case ((i / 250) % 3)
        0:       pv = 90;
        1:       pv = 30;
        default: pv = 4;
      endcase
      cycle($urandom_range(0, 99) < pv, 8'($urandom), $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) != 0, acc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
